// File: rtl/seg_mux_driver.sv
// seg_mux_driver: banked multiplexed 7-segment scanner with frame-latched inputs, masks, zero suppression and PWM
module seg_mux_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int BANKS = 2,
  parameter int CLK_DIV = 100000,
  parameter int PWM_BITS = 3,
  parameter int BLINK_DIV = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [8*BANKS-1:0]      seg,
  output logic                    frame_start
);
  localparam int DPB = NUM_DIGITS / BANKS;
  localparam int SW = DPB > 1 ? $clog2(DPB) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int FW = $clog2(BLINK_DIV + 1);
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] scan_idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FW-1:0] frame_cnt;
  logic blink_phase, lz_sh, tick, wrap;
  logic [4*NUM_DIGITS-1:0] dig_sh;
  logic [NUM_DIGITS-1:0] dp_sh, blank_sh, blink_sh, zpre, lit, an_d;
  logic [8*BANKS-1:0] seg_d;
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0: decode = 7'h7E;
      4'd1: decode = 7'h30;
      4'd2: decode = 7'h6D;
      4'd3: decode = 7'h79;
      4'd4: decode = 7'h33;
      4'd5: decode = 7'h5B;
      4'd6: decode = 7'h5F;
      4'd7: decode = 7'h70;
      4'd8: decode = 7'h7F;
      4'd9: decode = 7'h7B;
      default: decode = 7'h01;
    endcase
  endfunction
  assign tick = div_cnt == DW'(CLK_DIV - 1);
  assign wrap = tick && scan_idx == SW'(DPB - 1);
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_d
    localparam logic LAST = (i % DPB) == DPB - 1;
    // zpre: this digit and every digit left of it in its bank are zero
    assign zpre[i] = dig_sh[4*i+3 : 4*(i - i % DPB)] == '0;
    assign lit[i] = enable && !blank_sh[i] && !(blink_sh[i] && blink_phase)
                    && !(lz_sh && !LAST && zpre[i]) && pwm_cnt <= brightness;
    assign an_d[i] = lit[i] && scan_idx == SW'(i % DPB);
  end
  for (genvar b = 0; b < BANKS; b++) begin : g_b
    logic [DPB-1:0] lit_b, dp_b;
    logic [4*DPB-1:0] dig_b;
    assign lit_b = lit[b*DPB +: DPB];
    assign dp_b = dp_sh[b*DPB +: DPB];
    assign dig_b = dig_sh[4*DPB*b +: 4*DPB];
    assign seg_d[8*b +: 8] = lit_b[scan_idx] ? {dp_b[scan_idx], decode(dig_b[{scan_idx, 2'b00} +: 4])} : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      scan_idx <= '0;
      pwm_cnt <= '0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
      frame_start <= 1'b0;
      an <= '0;
      seg <= '0;
      dig_sh <= '0;
      dp_sh <= '0;
      blank_sh <= '1;
      blink_sh <= '0;
      lz_sh <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (tick) scan_idx <= (scan_idx == SW'(DPB - 1)) ? '0 : scan_idx + 1'b1;
      frame_start <= wrap;
      an <= an_d;
      seg <= seg_d;
      if (wrap) begin
        dig_sh <= digits;
        dp_sh <= dp_mask;
        blank_sh <= blank_mask;
        blink_sh <= blink_mask;
        lz_sh <= lz_en;
        frame_cnt <= (frame_cnt == FW'(BLINK_DIV - 1)) ? '0 : frame_cnt + 1'b1;
        if (frame_cnt == FW'(BLINK_DIV - 1)) blink_phase <= !blink_phase;
      end
    end
  end
endmodule

// File: tb/tb_seg_mux_driver.sv
// tb_seg_mux_driver: randomized scoreboard bench; the model derives the scan position purely from the cycle count
module tb_seg_mux_driver;
  localparam int ND = 8, NB = 2, CD = 4, PB = 2, BD = 2;
  localparam int DPB = ND / NB, FRAME = CD * DPB;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, lz_en = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic [ND-1:0] dp_mask = '0, blank_mask = '0, blink_mask = '0;
  logic [PB-1:0] brightness = '0;
  logic [ND-1:0] an;
  logic [8*NB-1:0] seg;
  logic frame_start;
  int checks = 0, fails = 0, n = 0, frames_seen = 0, frames_exp = 0;
  logic [24:0] q[$];
  logic [4*ND-1:0] m_dig = '0;
  logic [ND-1:0] m_dp = '0, m_blank = '1, m_blink = '0;
  logic m_lz = 1'b0;
  logic [6:0] dec_tab[16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};

  seg_mux_driver #(.NUM_DIGITS(ND), .BANKS(NB), .CLK_DIV(CD), .PWM_BITS(PB), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en), .brightness(brightness),
    .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got fs=%b an=%h seg=%h, expected fs=%b an=%h seg=%h (cycle %0d)",
               nm, got[24], got[23:16], got[15:0], exp[24], exp[23:16], exp[15:0], n);
    end
  endtask

  // Expected an/seg given how many clocks have elapsed since reset release
  function automatic logic [23:0] model_out(input int prev);
    int slot = (prev / CD) % DPB;
    int pwm = prev % (1 << PB);
    bit phase = ((prev / FRAME) / BD) % 2 == 1;
    logic [ND-1:0] a = '0;
    logic [8*NB-1:0] s = '0;
    for (int b = 0; b < NB; b++) begin
      int k = b * DPB + slot;
      bit zero_run = 1'b1;
      bit lit;
      for (int j = b * DPB; j <= k; j++) if (m_dig[4*j +: 4] != 4'h0) zero_run = 1'b0;
      lit = enable && !m_blank[k] && !(m_blink[k] && phase) && !(m_lz && slot != DPB - 1 && zero_run)
            && pwm <= int'(brightness);
      if (lit) begin
        a[k] = 1'b1;
        s[8*b +: 8] = {m_dp[k], dec_tab[m_dig[4*k +: 4]]};
      end
    end
    return {a, s};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      q.delete();
      m_dig = '0; m_dp = '0; m_blank = '1; m_blink = '0; m_lz = 1'b0;
    end else begin
      logic [23:0] o;
      logic fs;
      o = model_out(n);
      n++;
      fs = (n % FRAME) == 0;
      if (fs) begin
        m_dig = digits; m_dp = dp_mask; m_blank = blank_mask; m_blink = blink_mask; m_lz = lz_en;
        frames_exp++;
      end
      q.push_back({fs, o});
    end
  end

  always @(negedge clk) begin
    if (!rst_n) chk("reset_dark", {frame_start, an, seg}, 25'h0);
    else if (q.size() > 0) begin
      logic [24:0] e;
      e = q.pop_front();
      if (frame_start) frames_seen++;
      chk("scan_out", {frame_start, an, seg}, e);
    end
  end

  task automatic cyc(input int c);
    repeat (c) @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(3);
    digits = 32'h12345678; brightness = 2'd3; enable = 1'b1; rst_n = 1'b1;
    cyc(FRAME * 3 + 5);
    digits = 32'h0BCDE901;
    cyc(FRAME * 2);
    dp_mask = 8'h02; blank_mask = 8'h40;
    cyc(FRAME * 2);
    dp_mask = 8'h00; blank_mask = 8'h00; lz_en = 1'b1; digits = 32'h00120005;
    cyc(FRAME * 2);
    digits = 32'h00000005;
    cyc(FRAME * 2);
    digits = 32'h30000040; dp_mask = 8'hFF;
    cyc(FRAME * 2);
    lz_en = 1'b0; dp_mask = 8'h00; brightness = 2'd1;
    cyc(FRAME * 2);
    brightness = 2'd0;
    cyc(FRAME);
    brightness = 2'd3; blink_mask = 8'hFF;
    cyc(FRAME * 8);
    blink_mask = 8'h0F;
    cyc(FRAME * 2);
    blink_mask = 8'h00; enable = 1'b0;
    cyc(7);
    enable = 1'b1;
    cyc(FRAME + 6);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(FRAME * 2);
    repeat (300) begin
      for (int i = 0; i < ND; i++) digits[4*i +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      dp_mask = ND'($urandom());
      blank_mask = ND'($urandom() & $urandom() & $urandom());
      blink_mask = ND'($urandom() & $urandom());
      lz_en = 1'($urandom_range(0, 1));
      enable = $urandom_range(0, 7) != 0;
      brightness = PB'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      cyc($urandom_range(1, 12));
    end
    cyc(2);
    checks++;
    if (frames_seen != frames_exp || frames_exp == 0) begin
      fails++;
      $display("FAIL frame_count: got %0d frame_start pulses, expected %0d", frames_seen, frames_exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
